// File: rtl/jump_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jump_pkg
//  Description : Shared state encoding, default physics parameters and a
//                small width helper for the jump arc controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package jump_pkg;

   // Jump phase encoding; the value 3 is never produced
   typedef enum logic [1:0] {
      GROUND = 2'd0,
      RISE   = 2'd1,
      FALL   = 2'd2
   } jstate_t;

   // Default build values: 60 Hz physics tick from a 100 MHz clock
   localparam int TICK_DIV_DEF = 1666667;
   localparam int V0_DEF       = 16;
   localparam int G_DEF        = 1;
   localparam int HW_DEF       = 9;

   // Velocity register width (unsigned)
   localparam int VEL_W        = 6;

   // Larger of two integers, used to size comparison operands
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage : jump_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Free-running divider producing a one-cycle physics tick
//                every TICK_DIV clock cycles. The counter starts at zero on
//                reset so the first tick-driven update lands TICK_DIV edges
//                after reset is released.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen
   import jump_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF
)(
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A one-bit counter is kept even for TICK_DIV = 1; it simply stays at 0
   localparam int             CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0]  c_last = CW'(TICK_DIV - 1);

   logic [CW-1:0] r_cnt;

   // Count 0..TICK_DIV-1 continuously, wrapping on the terminal count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (r_cnt == c_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Tick is decoded from the registered count only
   assign tick = (r_cnt == c_last);

endmodule : tick_gen
`default_nettype wire

// File: rtl/jump.sv
`default_nettype none
// ============================================================================
//  Module      : jump
//  Description : Ballistic jump controller. A jump request on the ground
//                launches an arc: height rises by the current velocity each
//                physics tick while gravity bleeds velocity off, then falls
//                with growing velocity until it touches down. All outputs
//                are registers.
//  Revision    : 1.0 - initial release
// ============================================================================
module jump
   import jump_pkg::*;
#(
   parameter int TICK_DIV = TICK_DIV_DEF,
   parameter int V0       = V0_DEF,
   parameter int G        = G_DEF,
   parameter int HW       = HW_DEF
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          jump_req,
   output logic [1:0]    jumpstate,
   output logic [HW-1:0] hnow,
   output logic          landed
);

   // Comparison width wide enough for both the height and vel + G
   localparam int                AW   = max_int(HW, VEL_W + 1);
   localparam logic [VEL_W-1:0]  c_v0 = VEL_W'(V0);
   localparam logic [VEL_W-1:0]  c_g  = VEL_W'(G);

   jstate_t           r_state;
   logic [HW-1:0]     r_hnow;
   logic [VEL_W-1:0]  r_vel;
   logic              r_landed;

   logic              w_tick;
   logic [VEL_W:0]    w_vn;
   logic [HW-1:0]     w_rise_sum;
   logic [HW-1:0]     w_fall_diff;
   logic              w_touch;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (w_tick)
   );

   // Falling velocity after this tick; one extra bit so it never wraps
   assign w_vn        = {1'b0, r_vel} + {1'b0, c_g};

   // Rising height; the height width is sized to hold the apex
   assign w_rise_sum  = r_hnow + HW'(r_vel);

   // Touch-down when the remaining height cannot absorb a full step,
   // which also guarantees the subtraction below never underflows
   assign w_touch     = (AW'(r_hnow) <= AW'(w_vn));

   // Only consumed when w_touch is low, so the truncation is harmless
   assign w_fall_diff = r_hnow - HW'(w_vn);

   // Jump state machine with registered height, velocity and landed pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= GROUND;
         r_hnow   <= '0;
         r_vel    <= '0;
         r_landed <= 1'b0;
      end else begin
         r_landed <= 1'b0;
         case (r_state)
            GROUND: begin
               r_hnow <= '0;
               r_vel  <= '0;
               // Launch does not wait for a tick
               if (jump_req) begin
                  r_state <= RISE;
                  r_vel   <= c_v0;
               end
            end
            RISE: begin
               if (w_tick) begin
                  r_hnow <= w_rise_sum;
                  if (r_vel <= c_g) begin
                     r_vel   <= '0;
                     r_state <= FALL;
                  end else begin
                     r_vel   <= r_vel - c_g;
                  end
               end
            end
            FALL: begin
               if (w_tick) begin
                  if (w_touch) begin
                     r_hnow   <= '0;
                     r_vel    <= '0;
                     r_state  <= GROUND;
                     r_landed <= 1'b1;
                  end else begin
                     r_hnow   <= w_fall_diff;
                     r_vel    <= w_vn[VEL_W-1:0];
                  end
               end
            end
            default: begin
               // Unused encoding: return quietly to the ground
               r_state <= GROUND;
               r_hnow  <= '0;
               r_vel   <= '0;
            end
         endcase
      end
   end

   assign jumpstate = r_state;
   assign hnow      = r_hnow;
   assign landed    = r_landed;

endmodule : jump
`default_nettype wire

// File: tb/tb_jump.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jump
//  Description : Bench for jump. Three instances (default arc at TICK_DIV=4,
//                V0=3/G=2 at TICK_DIV=4, default arc at TICK_DIV=1) are
//                compared every cycle against a trajectory-table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jump;

   localparam int NI = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req [NI] = '{1'b0, 1'b0, 1'b0};
   logic [1:0] js  [NI];
   logic [8:0] hn  [NI];
   logic       ld  [NI];

   int div_of [NI] = '{4, 4, 1};
   int v0_of  [NI] = '{16, 3, 16};
   int g_of   [NI] = '{1, 2, 1};

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   jump #(.TICK_DIV(4), .V0(16), .G(1), .HW(9)) u_dut0 (
      .clk(clk), .rst(rst), .jump_req(req[0]),
      .jumpstate(js[0]), .hnow(hn[0]), .landed(ld[0]));

   jump #(.TICK_DIV(4), .V0(3), .G(2), .HW(9)) u_dut1 (
      .clk(clk), .rst(rst), .jump_req(req[1]),
      .jumpstate(js[1]), .hnow(hn[1]), .landed(ld[1]));

   jump #(.TICK_DIV(1), .V0(16), .G(1), .HW(9)) u_dut2 (
      .clk(clk), .rst(rst), .jump_req(req[2]),
      .jumpstate(js[2]), .hnow(hn[2]), .landed(ld[2]));

   // ---------------- reference model ----------------
   // Trajectory table per instance: entry k is (phase, height) after k ticks
   // of flight; reaching arc_len means touch-down.
   int arc_h [NI][80];
   int arc_s [NI][80];
   int arc_len [NI];

   task automatic build_arcs();
      for (int i = 0; i < NI; i++) begin
         int h, v, n;
         h = 0; v = v0_of[i]; n = 0;
         arc_h[i][0] = 0; arc_s[i][0] = 1;
         while (v > 0) begin
            n++;
            h = h + v;
            v = (v <= g_of[i]) ? 0 : v - g_of[i];
            arc_h[i][n] = h;
            arc_s[i][n] = (v == 0) ? 2 : 1;
         end
         forever begin
            n++;
            if (h <= v + g_of[i]) begin
               arc_h[i][n] = 0; arc_s[i][n] = 0;
               break;
            end
            v = v + g_of[i];
            h = h - v;
            arc_h[i][n] = h; arc_s[i][n] = 2;
         end
         arc_len[i] = n;
      end
   endtask

   int m_cnt [NI];
   int m_k   [NI];
   bit m_air [NI];
   bit m_land[NI];
   bit m_t;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_k[i] = 0; m_air[i] = 1'b0; m_land[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < NI; i++) begin
            m_t       = (m_cnt[i] == div_of[i] - 1);
            m_cnt[i]  = (m_cnt[i] + 1) % div_of[i];
            m_land[i] = 1'b0;
            if (!m_air[i]) begin
               if (req[i] === 1'b1) begin
                  m_air[i] = 1'b1;
                  m_k[i]   = 0;
               end
            end else if (m_t) begin
               m_k[i]++;
               if (m_k[i] == arc_len[i]) begin
                  m_air[i]  = 1'b0;
                  m_land[i] = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("state[%0d]", i), 32'(js[i]), m_air[i] ? arc_s[i][m_k[i]] : 0);
         chk($sformatf("hnow[%0d]", i),  32'(hn[i]), m_air[i] ? arc_h[i][m_k[i]] : 0);
         chk($sformatf("landed[%0d]", i), 32'(ld[i]), 32'(m_land[i]));
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      check_all();
   endtask

   // ---------------- stimulus ----------------
   int first_h0, peak0, peak2, fall2, gnd2, prev1;
   int lcnt [NI];
   int seq1 [$];
   int exp_seq [4] = '{3, 4, 2, 0};
   logic [1:0] pj0, pj2;
   bit found;

   initial begin
      build_arcs();

      // Reset values
      repeat (3) step();
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("rst_state[%0d]", i), 32'(js[i]), 0);
         chk($sformatf("rst_hnow[%0d]", i), 32'(hn[i]), 0);
         chk($sformatf("rst_landed[%0d]", i), 32'(ld[i]), 0);
      end
      rst = 1'b0;

      // One-cycle launch on all instances
      for (int i = 0; i < NI; i++) req[i] = 1'b1;
      step();
      for (int i = 0; i < NI; i++) chk($sformatf("launch[%0d]", i), 32'(js[i]), 1);
      for (int i = 0; i < NI; i++) req[i] = 1'b0;

      // Full arcs, with ignored mid-air requests
      first_h0 = -1; peak0 = -1; peak2 = -1; fall2 = -1; gnd2 = -1; prev1 = 0;
      for (int i = 0; i < NI; i++) lcnt[i] = 0;
      pj0 = js[0]; pj2 = js[2];
      for (int c = 1; c <= 140; c++) begin
         req[0] = (c == 10 || c == 100);
         req[2] = (c == 10);
         step();
         if (first_h0 < 0 && hn[0] != 0) first_h0 = int'(hn[0]);
         if (js[0] == 2'd2 && pj0 != 2'd2) peak0 = int'(hn[0]);
         if (js[2] == 2'd2 && pj2 != 2'd2) begin peak2 = int'(hn[2]); fall2 = c; end
         if (js[2] == 2'd0 && pj2 != 2'd0 && gnd2 < 0) gnd2 = c;
         if (int'(hn[1]) != prev1) begin seq1.push_back(int'(hn[1])); prev1 = int'(hn[1]); end
         for (int i = 0; i < NI; i++) if (ld[i] === 1'b1) lcnt[i]++;
         pj0 = js[0]; pj2 = js[2];
      end
      req[0] = 1'b0; req[2] = 1'b0;
      chk("first_tick_h0", first_h0, 16);
      chk("peak_h0", peak0, 136);
      chk("peak_h2", peak2, 136);
      chk("fall_cycle2", fall2, 16);
      chk("ground_cycle2", gnd2, 32);
      for (int i = 0; i < NI; i++) chk($sformatf("landed_count[%0d]", i), lcnt[i], 1);
      chk("end_state0", 32'(js[0]), 0);
      chk("end_hnow0", 32'(hn[0]), 0);
      chk("seq1_len", seq1.size(), 4);
      for (int k = 0; k < 4; k++)
         chk($sformatf("seq1[%0d]", k), (k < seq1.size()) ? seq1[k] : -1, exp_seq[k]);

      // Held request: relaunch one edge after landing
      req[0] = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 300 && !found; c++) begin
         step();
         if (ld[0] === 1'b1) found = 1'b1;
      end
      chk("held_landed_seen", 32'(found), 1);
      step();
      chk("held_relaunch", 32'(js[0]), 1);
      req[0] = 1'b0;

      // Asynchronous reset at the apex
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         step();
         if (hn[0] == 9'd136) found = 1'b1;
      end
      chk("apex_reached", 32'(found), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_state0", 32'(js[0]), 0);
      chk("async_hnow0", 32'(hn[0]), 0);
      chk("async_landed0", 32'(ld[0]), 0);
      check_all();
      step();
      step();
      rst = 1'b0;
      lcnt[0] = 0;
      repeat (10) begin
         step();
         if (ld[0] === 1'b1) lcnt[0]++;
      end
      chk("no_landed_after_rst", lcnt[0], 0);

      // Randomized requests with occasional asynchronous resets
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) req[i] = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #2 rst = 1'b1;
            #1 check_all();
            step();
            rst = 1'b0;
         end
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_jump
`default_nettype wire
